// File: rtl/wb_core_hub.sv
// Wishbone slave hub that decodes NUM_SLOTS core windows plus one register window,
// with per-access timeout, bad-address error and maskable sticky IRQ aggregation.
module wb_core_hub #(
    parameter int          NUM_SLOTS = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SLOT_AW   = 8,
    parameter int          TIMEOUT   = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_SLOTS-1:0]     slot_req_o,
    output logic                     slot_we_o,
    output logic [3:0]               slot_sel_o,
    output logic [SLOT_AW-3:0]       slot_addr_o,
    output logic [31:0]              slot_wdata_o,
    input  logic [NUM_SLOTS-1:0]     slot_ack_i,
    input  logic [32*NUM_SLOTS-1:0]  slot_rdata_i,
    input  logic [NUM_SLOTS-1:0]     slot_irq_i,
    output logic [2:0]               user_irq
);

    localparam int SW = $clog2(NUM_SLOTS + 1);
    localparam int CW = $clog2(TIMEOUT);
    localparam int OW = SLOT_AW - 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic [NUM_SLOTS-1:0]  req_q, req_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [OW-1:0]         addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [SW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]  mask_q, mask_d;
    logic [NUM_SLOTS-1:0]  pend_q, pend_d;
    logic [1:0]            err_q, err_d;
    logic [7:0]            err_id_q, err_id_d;
    logic [NUM_SLOTS-1:0]  irq_s_q, irq_s_d;
    logic [NUM_SLOTS-1:0]  irq_p_q, irq_p_d;
    logic [1:0]            uirq_q, uirq_d;

    logic [SW-1:0]         idx;
    logic [OW-1:0]         off;
    logic                  base_hit, is_core, is_hub, strobe;
    logic [31:0]           lane_mask, wbits, hub_rdata, slot_rd;
    logic                  slot_ack_hit;
    logic [NUM_SLOTS-1:0]  rise, pend_clr;
    logic [1:0]            err_set, err_clr;
    logic                  unused_ok;

    assign idx       = wbs_adr_i[SLOT_AW+SW-1:SLOT_AW];
    assign off       = wbs_adr_i[SLOT_AW-1:2];
    assign base_hit  = (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
    assign is_core   = base_hit && (idx < SW'(NUM_SLOTS));
    assign is_hub    = base_hit && (idx == SW'(NUM_SLOTS));
    assign strobe    = wbs_cyc_i & wbs_stb_i;
    assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wbits     = wbs_dat_i & lane_mask;
    assign rise      = irq_s_q & ~irq_p_q;
    // req_q is one-hot, so masking the acks with it ignores every non-selected slot
    assign slot_ack_hit = |(slot_ack_i & req_q);
    assign unused_ok    = ^{wbs_adr_i, wbs_dat_i, wbits};

    always_comb begin
        hub_rdata = 32'h0;
        if (off == OW'(0)) begin
            hub_rdata = {8'hA5, 8'(NUM_SLOTS), 16'h0002};
        end else if (off == OW'(1)) begin
            hub_rdata = {{(32-NUM_SLOTS){1'b0}}, mask_q};
        end else if (off == OW'(2)) begin
            hub_rdata = {{(32-NUM_SLOTS){1'b0}}, pend_q};
        end else if (off == OW'(3)) begin
            hub_rdata = {16'h0, err_id_q, 6'h0, err_q};
        end
    end

    always_comb begin
        slot_rd = 32'h0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (req_q[i]) begin
                slot_rd = slot_rdata_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        dat_d    = dat_q;
        req_d    = req_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        err_id_d = err_id_q;
        irq_s_d  = slot_irq_i;
        irq_p_d  = irq_s_q;
        uirq_d   = {|err_q, |(pend_q & mask_q)};
        pend_clr = '0;
        err_clr  = 2'b00;
        err_set  = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    if (is_hub) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        dat_d   = hub_rdata;
                        if (wbs_we_i) begin
                            if (off == OW'(1)) begin
                                mask_d = (mask_q & ~lane_mask[NUM_SLOTS-1:0]) | wbits[NUM_SLOTS-1:0];
                            end else if (off == OW'(2)) begin
                                pend_clr = wbits[NUM_SLOTS-1:0];
                            end else if (off == OW'(3)) begin
                                err_clr = wbits[1:0];
                            end
                        end
                    end else if (is_core) begin
                        state_d = S_WAIT;
                        req_d   = NUM_SLOTS'(1) << idx;
                        we_d    = wbs_we_i;
                        sel_d   = wbs_sel_i;
                        addr_d  = off;
                        wdata_d = wbs_dat_i;
                        idx_d   = idx;
                        cnt_d   = '0;
                    end else begin
                        state_d    = S_ACK;
                        ack_d      = 1'b1;
                        dat_d      = 32'hBADA_DD00;
                        err_set[1] = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // an abandoned cycle takes priority: the master no longer wants any ack
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                    req_d   = '0;
                end else if (slot_ack_hit) begin
                    state_d = S_ACK;
                    req_d   = '0;
                    ack_d   = 1'b1;
                    dat_d   = slot_rd;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = S_ACK;
                    req_d      = '0;
                    ack_d      = 1'b1;
                    dat_d      = 32'hDEAD_0000 | 32'(idx_q);
                    err_set[0] = 1'b1;
                    err_id_d   = 8'(idx_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                dat_d   = 32'h0;
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
                dat_d   = 32'h0;
                req_d   = '0;
            end
        endcase

        pend_d = (pend_q & ~pend_clr) | rise;
        err_d  = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            req_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            idx_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            pend_q   <= '0;
            err_q    <= 2'b00;
            err_id_q <= 8'h0;
            irq_s_q  <= '0;
            irq_p_q  <= '0;
            uirq_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            req_q    <= req_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
            irq_s_q  <= irq_s_d;
            irq_p_q  <= irq_p_d;
            uirq_q   <= uirq_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign slot_req_o   = req_q;
    assign slot_we_o    = we_q;
    assign slot_sel_o   = sel_q;
    assign slot_addr_o  = addr_q;
    assign slot_wdata_o = wdata_q;
    assign user_irq     = {1'b0, uirq_q};

endmodule

// File: tb/tb_wb_core_hub.sv
// Directed bench for wb_core_hub with default parameters (4 slots, hub window at 0x3000_0400).
module tb_wb_core_hub;

    logic         clk;
    logic         rst_n;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat;
    logic         ack;
    logic [31:0]  rdat;
    logic [3:0]   slot_req;
    logic         slot_we;
    logic [3:0]   slot_sel;
    logic [5:0]   slot_addr;
    logic [31:0]  slot_wdata;
    logic [3:0]   slot_ack;
    logic [127:0] slot_rdata;
    logic [3:0]   slot_irq;
    logic [2:0]   user_irq;

    int checks = 0;
    int failures = 0;

    wb_core_hub dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdat),
        .slot_req_o   (slot_req),
        .slot_we_o    (slot_we),
        .slot_sel_o   (slot_sel),
        .slot_addr_o  (slot_addr),
        .slot_wdata_o (slot_wdata),
        .slot_ack_i   (slot_ack),
        .slot_rdata_i (slot_rdata),
        .slot_irq_i   (slot_irq),
        .user_irq     (user_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One Wishbone access; lat counts clock edges from strobe sample to the edge where ack is seen
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int maxc,
                           output logic [31:0] rd, output int lat);
        bit done;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        lat = 0; rd = 32'h0; done = 0;
        while (!done) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack) begin
                rd = rdat;
                done = 1;
            end else if (lat >= maxc) begin
                lat = -1;
                done = 1;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        int lat;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0h exp=0", ack); end
        checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL rst_dat got=%0h exp=0", rdat); end
        checks++; if (slot_req !== 4'h0) begin failures++; $display("FAIL rst_req got=%0h exp=0", slot_req); end
        checks++; if (user_irq !== 3'h0) begin failures++; $display("FAIL rst_irq got=%0h exp=0", user_irq); end
        rst_n = 1'b1;
        wb_xfer(1'b0, 32'h3000_0400, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL id_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hA504_0002) begin failures++; $display("FAIL id_data got=%0h exp=a5040002", rd); end
        checks++; if (slot_req !== 4'h0) begin failures++; $display("FAIL id_noreq got=%0h exp=0", slot_req); end
    endtask

    task automatic test_core_write;
        logic [31:0] rd;
        int lat;
        bit seen;
        fork
            wb_xfer(1'b1, 32'h3000_0210, 32'h1234_5678, 4'hF, 10, rd, lat);
            begin
                seen = 0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    @(negedge clk);
                    if (slot_req != 4'h0) seen = 1;
                end
                checks++; if (slot_req !== 4'b0100) begin failures++; $display("FAIL cw_req got=%0h exp=4", slot_req); end
                checks++; if (slot_addr !== 6'h04) begin failures++; $display("FAIL cw_addr got=%0h exp=4", slot_addr); end
                checks++; if (slot_we !== 1'b1) begin failures++; $display("FAIL cw_we got=%0h exp=1", slot_we); end
                checks++; if (slot_wdata !== 32'h1234_5678) begin failures++; $display("FAIL cw_wdata got=%0h exp=12345678", slot_wdata); end
                checks++; if (slot_sel !== 4'hF) begin failures++; $display("FAIL cw_sel got=%0h exp=f", slot_sel); end
                slot_ack[0] = 1'b1;
                @(negedge clk);
                slot_ack[0] = 1'b0;
                checks++; if (slot_req !== 4'b0100) begin failures++; $display("FAIL cw_other_ack got=%0h exp=4", slot_req); end
                checks++; if (ack !== 1'b0) begin failures++; $display("FAIL cw_early_ack got=%0h exp=0", ack); end
                @(negedge clk);
                checks++; if (slot_addr !== 6'h04) begin failures++; $display("FAIL cw_hold got=%0h exp=4", slot_addr); end
                slot_ack[2] = 1'b1;
                @(negedge clk);
                slot_ack[2] = 1'b0;
                checks++; if (slot_req !== 4'h0) begin failures++; $display("FAIL cw_req_drop got=%0h exp=0", slot_req); end
            end
        join
        checks++; if (lat !== 4) begin failures++; $display("FAIL cw_lat got=%0d exp=4", lat); end
    endtask

    task automatic test_core_read;
        logic [31:0] rd;
        int lat;
        slot_ack = 4'b1000;
        wb_xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, 10, rd, lat);
        slot_ack = 4'b0000;
        checks++; if (lat !== 2) begin failures++; $display("FAIL cr_lat got=%0d exp=2", lat); end
        checks++; if (rd !== 32'hCAFE_0003) begin failures++; $display("FAIL cr_data got=%0h exp=cafe0003", rd); end
        @(negedge clk);
        checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL cr_dat_idle got=%0h exp=0", rdat); end
    endtask

    task automatic test_timeout;
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, 30, rd, lat);
        checks++; if (lat !== 17) begin failures++; $display("FAIL to_lat got=%0d exp=17", lat); end
        checks++; if (rd !== 32'hDEAD_0001) begin failures++; $display("FAIL to_data got=%0h exp=dead0001", rd); end
        wb_xfer(1'b0, 32'h3000_040C, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0000_0101) begin failures++; $display("FAIL to_err got=%0h exp=101", rd); end
        checks++; if (user_irq !== 3'b010) begin failures++; $display("FAIL to_irq got=%0h exp=2", user_irq); end
        wb_xfer(1'b1, 32'h3000_040C, 32'h1, 4'hF, 5, rd, lat);
        repeat (2) @(negedge clk);
        checks++; if (user_irq[1] !== 1'b0) begin failures++; $display("FAIL to_irq_clr got=%0h exp=0", user_irq[1]); end
        wb_xfer(1'b0, 32'h3000_040C, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL to_err_clr got=%0h exp=100", rd); end
    endtask

    task automatic test_bad_addr;
        logic [31:0] rd;
        int lat;
        fork
            wb_xfer(1'b0, 32'h3000_0600, 32'h0, 4'hF, 5, rd, lat);
            begin
                @(negedge clk);
                @(negedge clk);
                checks++; if (slot_req !== 4'h0) begin failures++; $display("FAIL bad_noreq got=%0h exp=0", slot_req); end
            end
        join
        checks++; if (lat !== 1) begin failures++; $display("FAIL bad_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hBADA_DD00) begin failures++; $display("FAIL bad_data got=%0h exp=badadd00", rd); end
        wb_xfer(1'b0, 32'h4000_0400, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'hBADA_DD00) begin failures++; $display("FAIL bad_base got=%0h exp=badadd00", rd); end
        wb_xfer(1'b0, 32'h3000_040C, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0000_0102) begin failures++; $display("FAIL bad_err got=%0h exp=102", rd); end
        checks++; if (user_irq[1] !== 1'b1) begin failures++; $display("FAIL bad_irq got=%0h exp=1", user_irq[1]); end
        wb_xfer(1'b0, 32'h3000_0410, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL undef_off got=%0h exp=0", rd); end
        wb_xfer(1'b1, 32'h3000_040C, 32'h3, 4'hF, 5, rd, lat);
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        int lat;
        wb_xfer(1'b1, 32'h3000_0404, 32'h2, 4'hF, 5, rd, lat);
        wb_xfer(1'b1, 32'h3000_0404, 32'hF, 4'b1110, 5, rd, lat);
        wb_xfer(1'b0, 32'h3000_0404, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h2) begin failures++; $display("FAIL mask_rd got=%0h exp=2", rd); end
        @(negedge clk);
        slot_irq = 4'b1010;
        @(negedge clk);
        slot_irq = 4'b0000;
        repeat (3) @(negedge clk);
        wb_xfer(1'b0, 32'h3000_0408, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'hA) begin failures++; $display("FAIL pend_rd got=%0h exp=a", rd); end
        checks++; if (user_irq[0] !== 1'b1) begin failures++; $display("FAIL irq0 got=%0h exp=1", user_irq[0]); end
        @(negedge clk);
        slot_irq[1] = 1'b1;
        wb_xfer(1'b1, 32'h3000_0408, 32'h2, 4'hF, 5, rd, lat);
        wb_xfer(1'b0, 32'h3000_0408, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'hA) begin failures++; $display("FAIL set_wins got=%0h exp=a", rd); end
        slot_irq = 4'b0000;
        wb_xfer(1'b1, 32'h3000_0408, 32'h8, 4'hF, 5, rd, lat);
        wb_xfer(1'b0, 32'h3000_0408, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h2) begin failures++; $display("FAIL pend_w1c got=%0h exp=2", rd); end
        wb_xfer(1'b1, 32'h3000_0408, 32'h2, 4'hF, 5, rd, lat);
        repeat (2) @(negedge clk);
        checks++; if (user_irq[0] !== 1'b0) begin failures++; $display("FAIL irq0_clr got=%0h exp=0", user_irq[0]); end
    endtask

    task automatic test_abort_reset;
        logic [31:0] rd;
        int lat;
        bit saw_ack;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0200; sel = 4'hF;
        @(negedge clk);
        checks++; if (slot_req !== 4'b0100) begin failures++; $display("FAIL ab_req got=%0h exp=4", slot_req); end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        checks++; if (slot_req !== 4'h0) begin failures++; $display("FAIL ab_drop got=%0h exp=0", slot_req); end
        saw_ack = 0;
        repeat (3) begin @(negedge clk); if (ack) saw_ack = 1; end
        checks++; if (saw_ack !== 1'b0) begin failures++; $display("FAIL ab_noack got=%0h exp=0", saw_ack); end
        wb_xfer(1'b0, 32'h3000_0700, 32'h0, 4'hF, 5, rd, lat);
        repeat (2) @(negedge clk);
        checks++; if (user_irq[1] !== 1'b1) begin failures++; $display("FAIL ab_pre_irq got=%0h exp=1", user_irq[1]); end
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0234; wdat = 32'h55AA_1234; sel = 4'h3;
        @(negedge clk);
        checks++; if (slot_addr !== 6'h0D) begin failures++; $display("FAIL rs_pre_addr got=%0h exp=d", slot_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (slot_req !== 4'h0) begin failures++; $display("FAIL rs_req got=%0h exp=0", slot_req); end
        checks++; if (slot_we !== 1'b0 || slot_sel !== 4'h0 || slot_addr !== 6'h0) begin failures++; $display("FAIL rs_bus got=%0h/%0h/%0h exp=0", slot_we, slot_sel, slot_addr); end
        checks++; if (slot_wdata !== 32'h0) begin failures++; $display("FAIL rs_wdata got=%0h exp=0", slot_wdata); end
        checks++; if (user_irq !== 3'h0) begin failures++; $display("FAIL rs_irq got=%0h exp=0", user_irq); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        slot_ack[2] = 1'b1;
        @(negedge clk);
        slot_ack[2] = 1'b0;
        saw_ack = 0;
        repeat (3) begin @(negedge clk); if (ack) saw_ack = 1; end
        checks++; if (saw_ack !== 1'b0) begin failures++; $display("FAIL rs_late_ack got=%0h exp=0", saw_ack); end
        wb_xfer(1'b0, 32'h3000_0404, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rs_mask got=%0h exp=0", rd); end
        wb_xfer(1'b0, 32'h3000_040C, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rs_err got=%0h exp=0", rd); end
    endtask

    initial begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        slot_ack = 4'h0; slot_irq = 4'h0;
        slot_rdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        rst_n = 1'b0;
        test_reset();
        test_core_write();
        test_core_read();
        test_timeout();
        test_bad_addr();
        test_irq();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
